// File: rtl/uart_pkg.sv
// Shared types and constants for the fifo-to-UART drain stage.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps; tick marks the last cycle of a bit.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte fifo one entry at a time and sends each byte as an 8N1 frame on tx.
//
// state | meaning
// IDLE  | tx high; pop the fifo as soon as it reports non-empty
// WAIT  | fifo read data valid; load shift register, restart bit timer
// START | start bit (low) for one bit period
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (high); frame_done on its last cycle
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rd_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           bit_idx;
  logic                 tick;
  logic                 clear;

  assign clear = (state == WAIT);

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clock (clock),
    .rst   (rst),
    .clear (clear),
    .tick  (tick)
  );

  // The pop strobe is gated by rst so a reset cycle can never consume a byte.
  assign fifo_rd    = (state == IDLE) && !fifo_empty && !rst;
  assign frame_done = (state == STOP) && tick;

  always_ff @(posedge clock) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= STOP_LVL;
      busy    <= 1'b0;
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state <= WAIT;
            busy  <= 1'b1;
          end
        end
        WAIT: begin
          shreg   <= fifo_rd_data;
          bit_idx <= '0;
          tx      <= START_LVL;
          state   <= START;
        end
        START: begin
          if (tick) begin
            tx    <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shreg <= shreg >> 1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              tx    <= STOP_LVL;
              state <= STOP;
            end else begin
              tx      <= shreg[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with a queue-based fifo model and a line-level frame decoder.
module tb_fifo_uart_tx;

  localparam int C     = 4;
  localparam int FRAME = 10 * C;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_rd, tx, busy, frame_done;

  logic       f_empty = 1'b1;
  logic       hold    = 1'b0;
  logic       wr      = 1'b0;
  logic [7:0] wdata   = 8'h00;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];
  logic [7:0] sb[$];
  int         starts[$];
  int         fds[$];
  int         nframes = 0;

  always #5 clock = ~clock;

  // hold lets the bench fill the fifo while the drain still sees it empty
  assign fifo_empty = f_empty | hold;

  fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clock        (clock),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd      (fifo_rd),
    .tx           (tx),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Fifo model: 31 usable entries, registered read data and empty flag, shares rst.
  always @(posedge clock) begin
    if (rst) begin
      q.delete();
      sb.delete();
      f_empty      <= 1'b1;
      fifo_rd_data <= 8'h00;
    end else begin
      if (fifo_rd && q.size() > 0) fifo_rd_data <= q.pop_front();
      if (wr && q.size() < 31) begin
        q.push_back(wdata);
        sb.push_back(wdata);
      end
      f_empty <= (q.size() == 0);
    end
  end

  logic rst_seen = 1'b1;
  always @(posedge clock) begin
    cyc++;
    rst_seen <= rst;
  end

  // Line decoder: every level must hold C cycles; bytes are compared in write order.
  int         dec_cnt = 0;
  logic       dec_lvl = 1'b1;
  logic [7:0] dec_byte = 8'h00;
  always @(negedge clock) begin
    if (rst_seen) begin
      dec_cnt = 0;
    end else begin
      if (frame_done) fds.push_back(cyc);
      if (dec_cnt == 0) begin
        check("frame_done_idle", frame_done, 0);
        if (tx == 1'b0) begin
          starts.push_back(cyc);
          dec_lvl  = 1'b0;
          dec_byte = 8'h00;
          dec_cnt  = 1;
          check("busy_start", busy, 1);
        end
      end else begin
        if (dec_cnt % C == 0) begin
          dec_lvl = tx;
          if (dec_cnt / C <= 8) dec_byte[dec_cnt/C-1] = tx;
          else check("stop_bit", tx, 1);
        end else begin
          check("bit_hold", tx, dec_lvl);
        end
        check("busy_frame", busy, 1);
        check("frame_done_pos", frame_done, dec_cnt == FRAME - 1);
        dec_cnt++;
        if (dec_cnt == FRAME) begin
          dec_cnt = 0;
          nframes++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got byte %0h, expected no frame", dec_byte);
          end else begin
            check("rx_byte", dec_byte, sb.pop_front());
          end
        end
      end
    end
  end

  logic prev_rd = 1'b0;
  always @(negedge clock) begin
    if (!rst_seen && fifo_rd) begin
      check("rd_when_empty", fifo_empty, 0);
      check("rd_when_busy", busy, 0);
      check("rd_back_to_back", prev_rd, 0);
    end
    prev_rd = fifo_rd;
  end

  task automatic write_byte(input logic [7:0] b);
    wr    = 1'b1;
    wdata = b;
    @(negedge clock);
    wr    = 1'b0;
  endtask

  task automatic wait_rd(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (fifo_rd) return;
      @(negedge clock);
    end
    checks++;
    errors++;
    $display("FAIL wait_rd: got no fifo_rd, expected one within %0d cycles", lim);
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (sb.size() == 0 && dec_cnt == 0 && !busy && fifo_empty) return;
      @(negedge clock);
    end
    checks++;
    errors++;
    $display("FAIL drain: got %0d bytes pending, expected 0 within %0d cycles", sb.size(), lim);
  endtask

  typedef struct {
    int   off;
    logic tx;
    logic busy;
    logic fd;
    logic rd;
  } vec_t;

  vec_t vecs[18];
  logic tr_tx[0:42], tr_busy[0:42], tr_fd[0:42], tr_rd[0:42];

  initial begin
    int base, fbase, nrd, blow, nf;
    logic [7:0] b;

    // Frame of 0xA5 (bits 1,0,1,0,0,1,0,1), offsets from the fifo_rd cycle.
    vecs[0]  = '{0,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{2,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{5,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{6,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{10, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{14, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{18, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{22, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{26, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{30, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{34, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{37, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{38, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{40, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{41, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{42, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{9,  1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_rd", fifo_rd, 0);
    check("rst_frame_done", frame_done, 0);
    rst = 1'b0;

    repeat (100) begin
      @(negedge clock);
      check("empty_tx", tx, 1);
      check("empty_busy", busy, 0);
      check("empty_rd", fifo_rd, 0);
    end

    write_byte(8'hA5);
    wait_rd(10);
    for (int o = 0; o <= 42; o++) begin
      tr_tx[o]   = tx;
      tr_busy[o] = busy;
      tr_fd[o]   = frame_done;
      tr_rd[o]   = fifo_rd;
      @(negedge clock);
    end
    nrd = 0;
    for (int o = 0; o <= 42; o++) if (tr_rd[o]) nrd++;
    for (int i = 0; i < 18; i++) begin
      check($sformatf("a5_tx@%0d", vecs[i].off), tr_tx[vecs[i].off], vecs[i].tx);
      check($sformatf("a5_busy@%0d", vecs[i].off), tr_busy[vecs[i].off], vecs[i].busy);
      check($sformatf("a5_fd@%0d", vecs[i].off), tr_fd[vecs[i].off], vecs[i].fd);
      check($sformatf("a5_rd@%0d", vecs[i].off), tr_rd[vecs[i].off], vecs[i].rd);
    end
    check("a5_rd_pulses", nrd, 1);
    drain(20);

    base = starts.size();
    write_byte(8'h00);
    write_byte(8'hFF);
    write_byte(8'h3C);
    blow = 0;
    for (int i = 0; i < 200 && starts.size() < base + 3; i++) begin
      if (starts.size() > base && !busy) blow++;
      @(negedge clock);
    end
    if (starts.size() >= base + 3) begin
      check("burst_spacing_1", starts[base+1] - starts[base], FRAME + 2);
      check("burst_spacing_2", starts[base+2] - starts[base+1], FRAME + 2);
      check("burst_busy_low", blow, 2);
    end else begin
      checks++;
      errors++;
      $display("FAIL burst_starts: got %0d frames, expected 3", starts.size() - base);
    end
    drain(200);

    write_byte(8'h11);
    wait_rd(10);
    fbase = fds.size();
    base  = starts.size();
    repeat (20) @(negedge clock);
    write_byte(8'h5A);
    drain(200);
    if (fds.size() > fbase && starts.size() > base + 1) begin
      // IDLE and WAIT sit between frame_done and the next start bit
      check("write_mid_frame_gap", starts[base+1] - fds[fbase], 3);
    end else begin
      checks++;
      errors++;
      $display("FAIL write_mid_frame: got %0d frames, expected 2", starts.size() - base);
    end

    write_byte(8'h81);
    wait_rd(10);
    repeat (19) @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_fd", frame_done, 0);
    check("midrst_rd", fifo_rd, 0);
    rst = 1'b0;
    repeat (60) begin
      @(negedge clock);
      check("post_rst_tx", tx, 1);
      check("post_rst_busy", busy, 0);
      check("post_rst_rd", fifo_rd, 0);
    end

    hold = 1'b1;
    write_byte(8'h42);
    rst  = 1'b1;
    hold = 1'b0;
    #1;
    check("rst_pop_empty", fifo_empty, 0);
    check("rst_pop_rd", fifo_rd, 0);
    @(negedge clock);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clock);
      check("rst_pop_idle_busy", busy, 0);
    end

    hold = 1'b1;
    for (int i = 0; i < 31; i++) write_byte(8'((i * 37 + 5) & 8'hFF));
    nf   = nframes;
    hold = 1'b0;
    drain(31 * (FRAME + 2) + 100);
    check("full_frames", nframes - nf, 31);

    nf = nframes;
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom_range(0, 255));
      write_byte(b);
      repeat ($urandom_range(0, 50)) @(negedge clock);
    end
    drain(24 * (FRAME + 2) + 100);
    check("random_frames", nframes - nf, 24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
